trdb_packet_parser: RTL and testbench



---
 rtl/trdb_packet_parser.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_trdb_packet_parser.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_packet_parser.sv
`default_nettype none
// trdb_packet_parser: reassembles length-prefixed trace packets from a byte stream and decodes one record.
// Build option TRDB_PARSER_DIFF_ADDR_EN: DIFF_DELTA addresses are relative to the last absolute address.
module trdb_packet_parser #(
  parameter int XLEN              = 32,
  parameter int PRIV_LEN          = 3,
  parameter int CAUSE_LEN         = 5,
  parameter int TVAL_LEN          = 32,
  parameter int IOPT_LEN          = 3,
  parameter int MAX_PAYLOAD_BYTES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [7:0]           in_data_i,
  output logic                 in_ready_o,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic [1:0]           pkt_format_o,
  output logic [1:0]           pkt_subformat_o,
  output logic                 branch_o,
  output logic [PRIV_LEN-1:0]  priv_o,
  output logic [CAUSE_LEN-1:0] cause_o,
  output logic                 interrupt_o,
  output logic                 thaddr_o,
  output logic [TVAL_LEN-1:0]  tval_o,
  output logic [4:0]           branches_o,
  output logic [30:0]          branch_map_o,
  output logic                 notify_o,
  output logic                 updiscon_o,
  output logic                 ienable_o,
  output logic                 encoder_mode_o,
  output logic [1:0]           qual_status_o,
  output logic [IOPT_LEN-1:0]  ioptions_o,
  output logic [XLEN-1:0]      addr_o,
  output logic                 addr_present_o,
  output logic                 err_o
);

  localparam int PW         = MAX_PAYLOAD_BYTES * 8;
  localparam int START_BITS = 5 + PRIV_LEN + XLEN;
  localparam int TRAP_BITS  = 7 + PRIV_LEN + CAUSE_LEN + XLEN + TVAL_LEN;
  localparam int CTX_BITS   = 4 + PRIV_LEN;
  localparam int SUP_BITS   = 8 + IOPT_LEN;
  localparam int ADDR_BITS  = 4 + XLEN;
  localparam int DNA_BITS   = 38;
  localparam int DA_BITS    = 40 + XLEN;

  localparam logic [7:0] START_B = 8'((START_BITS + 7) / 8);
  localparam logic [7:0] TRAP_B  = 8'((TRAP_BITS + 7) / 8);
  localparam logic [7:0] CTX_B   = 8'((CTX_BITS + 7) / 8);
  localparam logic [7:0] SUP_B   = 8'((SUP_BITS + 7) / 8);
  localparam logic [7:0] ADDR_B  = 8'((ADDR_BITS + 7) / 8);
  localparam logic [7:0] DNA_B   = 8'((DNA_BITS + 7) / 8);
  localparam logic [7:0] DA_B    = 8'((DA_BITS + 7) / 8);
  localparam logic [7:0] MAX_B   = 8'(MAX_PAYLOAD_BYTES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_DROP    = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]    r_state, w_next;
  logic [7:0]    r_len, r_cnt;
  logic [PW-1:0] r_shift;
  logic          r_rdy_en, r_err;
  logic          w_acc, w_last, w_ready_st, w_valid_st, w_err;

  logic [7:0]    w_pad;
  logic [PW-1:0] w_al;
  logic          w_unused_pad;

  logic [1:0]           w_d_fmt, w_d_sf, w_d_qual;
  logic                 w_d_branch, w_d_intr, w_d_thaddr, w_d_notify, w_d_updiscon;
  logic                 w_d_ienable, w_d_emode, w_d_ap;
  logic [PRIV_LEN-1:0]  w_d_priv;
  logic [CAUSE_LEN-1:0] w_d_cause;
  logic [TVAL_LEN-1:0]  w_d_tval;
  logic [4:0]           w_d_branches;
  logic [30:0]          w_d_map;
  logic [IOPT_LEN-1:0]  w_d_iopt;
  logic [XLEN-1:0]      w_d_addr;
  logic [7:0]           w_need;
  logic                 w_fmt_ok, w_sync_ok, w_dec_ok;

  logic [1:0]           r_fmt, r_sf, r_qual;
  logic                 r_branch, r_intr, r_thaddr, r_notify, r_updiscon;
  logic                 r_ienable, r_emode, r_ap;
  logic [PRIV_LEN-1:0]  r_priv;
  logic [CAUSE_LEN-1:0] r_cause;
  logic [TVAL_LEN-1:0]  r_tval;
  logic [4:0]           r_branches;
  logic [30:0]          r_map;
  logic [IOPT_LEN-1:0]  r_iopt;
  logic [XLEN-1:0]      r_addr;
`ifdef TRDB_PARSER_DIFF_ADDR_EN
  logic [XLEN-1:0]      r_latest;
  logic                 r_latest_valid;
`endif

  assign w_acc  = in_valid_i & in_ready_o;
  assign w_last = (r_cnt == r_len - 8'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_acc && in_data_i != 8'd0)
                   w_next = (in_data_i > MAX_B) ? S_DROP : S_COLLECT;
      S_COLLECT: if (w_acc && w_last) w_next = S_DECODE;
      S_DROP:    if (w_acc && w_last) w_next = S_IDLE;
      S_DECODE:  w_next = w_dec_ok ? S_HOLD : S_IDLE;
      S_HOLD:    if (pkt_ready_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready_st = 1'b0;
    w_valid_st = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE:    begin w_ready_st = 1'b1; w_err = w_acc && (in_data_i == 8'd0); end
      S_COLLECT: w_ready_st = 1'b1;
      S_DROP:    begin w_ready_st = 1'b1; w_err = w_acc && w_last; end
      S_DECODE:  w_err = ~w_dec_ok;
      S_HOLD:    w_valid_st = 1'b1;
      default:   ;
    endcase
  end

  // in_ready_o stays low until the first clock after reset release
  assign in_ready_o  = r_rdy_en & w_ready_st;
  assign pkt_valid_o = w_valid_st;
  assign err_o       = r_err;

  // Left-align the N collected bytes so every field sits at a fixed offset from the top
  assign w_pad        = MAX_B - r_len;
  assign w_al         = r_shift << {w_pad, 3'b000};
  assign w_unused_pad = ^w_al[PW-TRAP_BITS-1:0];

  always_comb begin
    w_d_fmt = w_al[PW-1 -: 2];
    w_d_sf = '0; w_d_qual = '0; w_d_branch = 1'b0; w_d_intr = 1'b0; w_d_thaddr = 1'b0;
    w_d_notify = 1'b0; w_d_updiscon = 1'b0; w_d_ienable = 1'b0; w_d_emode = 1'b0;
    w_d_ap = 1'b0; w_d_priv = '0; w_d_cause = '0; w_d_tval = '0; w_d_branches = '0;
    w_d_map = '0; w_d_iopt = '0; w_d_addr = '0;
    w_need = 8'd1; w_fmt_ok = 1'b1; w_sync_ok = 1'b1;
    case (w_d_fmt)
      2'd1: begin
        w_d_branches = w_al[PW-3 -: 5];
        w_d_map      = w_al[PW-8 -: 31];
        if (w_d_branches != 5'd31) begin
          w_need       = DA_B;
          w_d_ap       = 1'b1;
          w_d_notify   = w_al[PW-39-XLEN];
          w_d_updiscon = w_al[PW-40-XLEN];
`ifdef TRDB_PARSER_DIFF_ADDR_EN
          w_d_addr     = r_latest + w_al[PW-39 -: XLEN];
          w_sync_ok    = r_latest_valid;
`else
          w_d_addr     = w_al[PW-39 -: XLEN];
`endif
        end else begin
          w_need = DNA_B;
        end
      end
      2'd2: begin
        w_need       = ADDR_B;
        w_d_ap       = 1'b1;
        w_d_addr     = w_al[PW-3 -: XLEN];
        w_d_notify   = w_al[PW-3-XLEN];
        w_d_updiscon = w_al[PW-4-XLEN];
      end
      2'd3: begin
        w_d_sf = w_al[PW-3 -: 2];
        case (w_d_sf)
          2'd0: begin
            w_need     = START_B;
            w_d_ap     = 1'b1;
            w_d_branch = w_al[PW-5];
            w_d_priv   = w_al[PW-6 -: PRIV_LEN];
            w_d_addr   = w_al[PW-6-PRIV_LEN -: XLEN];
          end
          2'd1: begin
            w_need     = TRAP_B;
            w_d_ap     = 1'b1;
            w_d_branch = w_al[PW-5];
            w_d_priv   = w_al[PW-6 -: PRIV_LEN];
            w_d_cause  = w_al[PW-6-PRIV_LEN -: CAUSE_LEN];
            w_d_intr   = w_al[PW-6-PRIV_LEN-CAUSE_LEN];
            w_d_thaddr = w_al[PW-7-PRIV_LEN-CAUSE_LEN];
            w_d_addr   = w_al[PW-8-PRIV_LEN-CAUSE_LEN -: XLEN];
            w_d_tval   = w_al[PW-8-PRIV_LEN-CAUSE_LEN-XLEN -: TVAL_LEN];
          end
          2'd2: begin
            w_need   = CTX_B;
            w_d_priv = w_al[PW-5 -: PRIV_LEN];
          end
          default: begin
            w_need      = SUP_B;
            w_d_ienable = w_al[PW-5];
            w_d_emode   = w_al[PW-6];
            w_d_qual    = w_al[PW-7 -: 2];
            w_d_iopt    = w_al[PW-9 -: IOPT_LEN];
          end
        endcase
      end
      default: w_fmt_ok = 1'b0;
    endcase
    w_dec_ok = w_fmt_ok & w_sync_ok & (r_len >= w_need);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdy_en <= 1'b0; r_err <= 1'b0; r_len <= '0; r_cnt <= '0; r_shift <= '0;
      r_fmt <= '0; r_sf <= '0; r_qual <= '0; r_branch <= 1'b0; r_intr <= 1'b0;
      r_thaddr <= 1'b0; r_notify <= 1'b0; r_updiscon <= 1'b0; r_ienable <= 1'b0;
      r_emode <= 1'b0; r_ap <= 1'b0; r_priv <= '0; r_cause <= '0; r_tval <= '0;
      r_branches <= '0; r_map <= '0; r_iopt <= '0; r_addr <= '0;
`ifdef TRDB_PARSER_DIFF_ADDR_EN
      r_latest <= '0; r_latest_valid <= 1'b0;
`endif
    end else begin
      r_rdy_en <= 1'b1;
      r_err    <= w_err;
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_len <= in_data_i;
          r_cnt <= 8'd0;
        end
        S_COLLECT: if (w_acc) begin
          r_shift <= {r_shift[PW-9:0], in_data_i};
          r_cnt   <= r_cnt + 8'd1;
        end
        S_DROP: if (w_acc) r_cnt <= r_cnt + 8'd1;
        S_DECODE: if (w_dec_ok) begin
          r_fmt <= w_d_fmt; r_sf <= w_d_sf; r_qual <= w_d_qual; r_branch <= w_d_branch;
          r_intr <= w_d_intr; r_thaddr <= w_d_thaddr; r_notify <= w_d_notify;
          r_updiscon <= w_d_updiscon; r_ienable <= w_d_ienable; r_emode <= w_d_emode;
          r_ap <= w_d_ap; r_priv <= w_d_priv; r_cause <= w_d_cause; r_tval <= w_d_tval;
          r_branches <= w_d_branches; r_map <= w_d_map; r_iopt <= w_d_iopt;
          r_addr <= w_d_addr;
`ifdef TRDB_PARSER_DIFF_ADDR_EN
          if (w_d_ap) begin
            r_latest       <= w_d_addr;
            r_latest_valid <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign pkt_format_o    = r_fmt;
  assign pkt_subformat_o = r_sf;
  assign branch_o        = r_branch;
  assign priv_o          = r_priv;
  assign cause_o         = r_cause;
  assign interrupt_o     = r_intr;
  assign thaddr_o        = r_thaddr;
  assign tval_o          = r_tval;
  assign branches_o      = r_branches;
  assign branch_map_o    = r_map;
  assign notify_o        = r_notify;
  assign updiscon_o      = r_updiscon;
  assign ienable_o       = r_ienable;
  assign encoder_mode_o  = r_emode;
  assign qual_status_o   = r_qual;
  assign ioptions_o      = r_iopt;
  assign addr_o          = r_addr;
  assign addr_present_o  = r_ap;

endmodule
`default_nettype wire

// File: tb/tb_trdb_packet_parser.sv
`default_nettype none
// tb_trdb_packet_parser: directed and randomized packets checked against a field-level reference model.
module tb_trdb_packet_parser;

  logic clk = 1'b0;
  logic rst_ni, in_valid_i, in_ready_o, pkt_valid_o, pkt_ready_i, err_o;
  logic [7:0] in_data_i;
  logic [1:0] pkt_format_o, pkt_subformat_o, qual_status_o;
  logic branch_o, interrupt_o, thaddr_o, notify_o, updiscon_o, ienable_o, encoder_mode_o, addr_present_o;
  logic [2:0] priv_o, ioptions_o;
  logic [4:0] cause_o, branches_o;
  logic [31:0] tval_o, addr_o;
  logic [30:0] branch_map_o;

  trdb_packet_parser dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o), .branch_o(branch_o),
    .priv_o(priv_o), .cause_o(cause_o), .interrupt_o(interrupt_o), .thaddr_o(thaddr_o),
    .tval_o(tval_o), .branches_o(branches_o), .branch_map_o(branch_map_o), .notify_o(notify_o),
    .updiscon_o(updiscon_o), .ienable_o(ienable_o), .encoder_mode_o(encoder_mode_o),
    .qual_status_o(qual_status_o), .ioptions_o(ioptions_o), .addr_o(addr_o),
    .addr_present_o(addr_present_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] fmt, sf, qual;
    logic branch, intr, thaddr, notify, updiscon, ienable, emode, ap;
    logic [2:0] priv, iopt;
    logic [4:0] cause, branches;
    logic [31:0] tval, addr;
    logic [30:0] map;
  } rec_t;

  int n_total = 0, n_pass = 0;
  int err_cnt = 0, vld_cnt = 0;
  logic prev_v = 1'b0;
  logic [31:0] m_latest = '0;
  bit m_lvalid = 1'b0;
`ifdef TRDB_PARSER_DIFF_ADDR_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  always @(negedge clk) begin
    if (err_o) err_cnt <= err_cnt + 1;
    if (pkt_valid_o && !prev_v) vld_cnt <= vld_cnt + 1;
    prev_v <= pkt_valid_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid_i = 1'b1; in_data_i = b;
    while (!in_ready_o && t < 50) begin tick(); t++; end
    if (t >= 50) chk("ready_timeout", {63'd0, in_ready_o}, 64'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!pkt_valid_o && t < 20) begin tick(); t++; end
    chk("valid_timeout", {63'd0, pkt_valid_o}, 64'd1);
  endtask

  task automatic release_rec();
    pkt_ready_i = 1'b1; tick(); pkt_ready_i = 1'b0;
    chk("valid_drop", {63'd0, pkt_valid_o}, 64'd0);
  endtask

  task automatic chk_rec(input rec_t e);
    chk("fmt", pkt_format_o, e.fmt);        chk("sf", pkt_subformat_o, e.sf);
    chk("branch", branch_o, e.branch);      chk("priv", priv_o, e.priv);
    chk("cause", cause_o, e.cause);         chk("intr", interrupt_o, e.intr);
    chk("thaddr", thaddr_o, e.thaddr);      chk("tval", tval_o, e.tval);
    chk("branches", branches_o, e.branches); chk("map", branch_map_o, e.map);
    chk("notify", notify_o, e.notify);      chk("updiscon", updiscon_o, e.updiscon);
    chk("ienable", ienable_o, e.ienable);   chk("emode", encoder_mode_o, e.emode);
    chk("qual", qual_status_o, e.qual);     chk("iopt", ioptions_o, e.iopt);
    chk("addr", addr_o, e.addr);            chk("addr_present", addr_present_o, e.ap);
  endtask

  // Field concatenation in wire order, left-aligned into 128 bits
  function automatic void encode(input rec_t r, output logic [127:0] v, output int L);
    logic [127:0] t;
    t = '0; L = 8;
    case (r.fmt)
      2'd1: if (r.branches == 5'd31) begin L = 38; t = 128'({r.fmt, r.branches, r.map}); end
            else begin L = 72; t = 128'({r.fmt, r.branches, r.map, r.addr, r.notify, r.updiscon}); end
      2'd2: begin L = 36; t = 128'({r.fmt, r.addr, r.notify, r.updiscon}); end
      2'd3: case (r.sf)
        2'd0: begin L = 40; t = 128'({r.fmt, r.sf, r.branch, r.priv, r.addr}); end
        2'd1: begin L = 79; t = 128'({r.fmt, r.sf, r.branch, r.priv, r.cause, r.intr, r.thaddr, r.addr, r.tval}); end
        2'd2: begin L = 7;  t = 128'({r.fmt, r.sf, r.priv}); end
        default: begin L = 11; t = 128'({r.fmt, r.sf, r.ienable, r.emode, r.qual, r.iopt}); end
      endcase
      default: begin L = 8; t = '0; end
    endcase
    v = t << (128 - L);
  endfunction

  function automatic rec_t gen_rec(input int kind);
    rec_t r;
    r = '{default: '0};
    case (kind)
      0: begin r.fmt = 3; r.sf = 0; r.branch = 1'($urandom); r.priv = 3'($urandom); r.addr = $urandom; end
      1: begin r.fmt = 3; r.sf = 1; r.branch = 1'($urandom); r.priv = 3'($urandom); r.cause = 5'($urandom);
               r.intr = 1'($urandom); r.thaddr = 1'($urandom); r.addr = $urandom; r.tval = $urandom; end
      2: begin r.fmt = 3; r.sf = 2; r.priv = 3'($urandom); end
      3: begin r.fmt = 3; r.sf = 3; r.ienable = 1'($urandom); r.emode = 1'($urandom);
               r.qual = 2'($urandom); r.iopt = 3'($urandom); end
      4: begin r.fmt = 2; r.addr = $urandom; r.notify = 1'($urandom); r.updiscon = 1'($urandom); end
      default: begin
        r.fmt = 1; r.map = 31'($urandom);
        r.branches = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
        if (r.branches != 5'd31) begin r.addr = $urandom; r.notify = 1'($urandom); r.updiscon = 1'($urandom); end
      end
    endcase
    return r;
  endfunction

  // Send one packet (n_force > 0 forces the length) and check record or error against the model
  task automatic run_rec(input rec_t raw, input int n_force);
    logic [127:0] v;
    int L, minb, n, e0, v0;
    bit exp_err, diff_addr;
    rec_t e;
    encode(raw, v, L);
    minb = (L + 7) / 8;
    n = (n_force > 0) ? n_force : minb + $urandom_range(0, 16 - minb);
    for (int i = 0; i < 128; i++)
      if (i < 128 - L && i >= 128 - 8 * n) v[i] = 1'($urandom);
    e = raw;
    diff_addr = (raw.fmt == 2'd1) && (raw.branches != 5'd31);
    e.ap = (raw.fmt == 2'd2) || (raw.fmt == 2'd3 && raw.sf <= 2'd1) || diff_addr;
    exp_err = (n < minb) || (raw.fmt == 2'd0);
    if (diff_addr && REL) begin
      if (!m_lvalid) exp_err = 1'b1;
      e.addr = m_latest + raw.addr;
    end
    e0 = err_cnt; v0 = vld_cnt;
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(v[127 - 8 * i -: 8]);
    if (exp_err) begin
      repeat (3) tick();
      chk("err_pulse", 64'(err_cnt - e0), 64'd1);
      chk("no_record", 64'(vld_cnt - v0), 64'd0);
    end else begin
      wait_valid();
      chk_rec(e);
      repeat ($urandom_range(0, 2)) tick();
      release_rec();
      chk("no_err", 64'(err_cnt - e0), 64'd0);
      if (e.ap) begin m_latest = e.addr; m_lvalid = 1'b1; end
    end
  endtask

  initial begin
    logic [7:0] q[$];
    rec_t r;
    int e0, v0;
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; pkt_ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_ready", in_ready_o, 0); chk("rst_valid", pkt_valid_o, 0);
    chk("rst_err", err_o, 0);        chk("rst_addr", addr_o, 0);
    chk("rst_fmt", pkt_format_o, 0); chk("rst_ap", addr_present_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("ready_after_rst", in_ready_o, 1);

    // DIFF_DELTA before any sync: error when relative addressing is built in, raw record otherwise
    r = gen_rec(5); r.branches = 5'd2;
    run_rec(r, 0);

    q = '{8'h05, 8'hCB, 8'h80, 8'h00, 8'h00, 8'h00};
    send_list(q);
    chk("lat_decode", pkt_valid_o, 0);
    tick();
    chk("lat_hold", pkt_valid_o, 1);
    chk("t1_fmt", pkt_format_o, 3);  chk("t1_sf", pkt_subformat_o, 0);
    chk("t1_branch", branch_o, 1);   chk("t1_priv", priv_o, 3);
    chk("t1_addr", addr_o, 32'h8000_0000); chk("t1_ap", addr_present_o, 1);
    chk("t1_tval", tval_o, 0);
    release_rec();
    m_latest = 32'h8000_0000; m_lvalid = 1'b1;

    q = '{8'h09, 8'h44, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h40};
    send_list(q);
    wait_valid();
    in_valid_i = 1'b1; in_data_i = 8'h05;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", pkt_valid_o, 1); chk("stall_ready", in_ready_o, 0);
      chk("t2_fmt", pkt_format_o, 1);     chk("t2_branches", branches_o, 2);
      chk("t2_map", branch_map_o, 1);
      chk("t2_addr", addr_o, REL ? 32'h8000_0010 : 32'h0000_0010);
    end
    pkt_ready_i = 1'b1; tick(); pkt_ready_i = 1'b0;
    chk("resume_valid", pkt_valid_o, 0);
    chk("resume_ready", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    q = '{8'hCB, 8'h80, 8'h00, 8'h00, 8'h10};
    send_list(q);
    wait_valid();
    chk("resume_fmt", pkt_format_o, 3);
    chk("resume_addr", addr_o, 32'h8000_0010);
    release_rec();
    m_latest = 32'h8000_0010;

    e0 = err_cnt; v0 = vld_cnt;
    send_byte(8'h00);
    chk("zero_len_err", err_o, 1);
    tick();
    chk("zero_len_pulse", err_o, 0);
    send_byte(8'h14);
    for (int i = 0; i < 20; i++) begin
      chk("drop_no_err", err_o, 0);
      send_byte(8'($urandom));
    end
    chk("drop_err", err_o, 1);
    tick();
    chk("drop_idle", in_ready_o, 1);
    chk("drop_err_count", 64'(err_cnt - e0), 2);
    chk("drop_no_record", 64'(vld_cnt - v0), 0);

    r = '{default: '0};
    run_rec(r, 1);
    r = gen_rec(0);
    run_rec(r, 4);
    r = gen_rec(1);
    run_rec(r, 16);

    e0 = err_cnt;
    q = '{8'h05, 8'hCB, 8'h80, 8'h00};
    send_list(q);
    rst_ni = 1'b0; #1;
    chk("mid_rst_ready", in_ready_o, 0); chk("mid_rst_valid", pkt_valid_o, 0);
    chk("mid_rst_addr", addr_o, 0);      chk("mid_rst_fmt", pkt_format_o, 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    m_latest = '0; m_lvalid = 1'b0;
    tick();
    chk("mid_rst_no_err", 64'(err_cnt - e0), 0);
    run_rec(gen_rec(2), 0);
    r = gen_rec(5); r.branches = 5'd7;
    run_rec(r, 0);
    run_rec(gen_rec(0), 0);

    for (int k = 0; k < 40; k++) run_rec(gen_rec($urandom_range(0, 5)), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
